// File: rtl/seg_pkg.sv
// seg_pkg: shared scan states, anode patterns and hex segment table for seg_scan.
package seg_pkg;
  typedef enum logic {BLANK, DRIVE} state_t;
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg_scan_hex7seg.sv
// hex7seg: active-low seven-segment decode of one hex nibble.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_TAB[hex];
endmodule

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment scanner with blanking dead time
// and a frame-synchronous shadow register so a frame never shows mixed data.
module seg_scan #(
  parameter int DIV   = 2500,
  parameter int BLANK = 8
) (
  input  logic        scan_clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [3:0]  AN,
  output logic [7:0]  SEG,
  output logic        pending,
  output logic        frame_sync
);
  import seg_pkg::*;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  dig, dig_n;
  state_t      state, state_n;
  disp_t       shadow, active, active_n, in_w;
  logic        boundary, slot_end;
  logic [3:0]  nib;
  logic [6:0]  hex_seg;
  assign in_w     = {data, dp, blank};
  assign boundary = cnt == 16'd0 && dig == 2'd3;
  assign slot_end = cnt == 16'(DIV - 1);
  assign cnt_n    = slot_end ? 16'd0 : cnt + 16'd1;
  assign dig_n    = slot_end ? dig - 2'd1 : dig;
  assign state_n  = slot_end ? seg_pkg::BLANK : (cnt_n == 16'(BLANK) ? seg_pkg::DRIVE : state);
  // A load in the boundary cycle itself goes straight to the active register.
  assign active_n = boundary ? (load ? in_w : (pending ? shadow : active)) : active;
  assign nib      = active_n.data[{dig_n, 2'b00} +: 4];
  hex7seg u_hex (.hex(nib), .seg(hex_seg));
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      dig        <= 2'd3;
      state      <= seg_pkg::BLANK;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      AN         <= AN_OFF;
      SEG        <= 8'hFF;
      frame_sync <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      dig        <= dig_n;
      state      <= state_n;
      active     <= active_n;
      shadow     <= (load && !boundary) ? in_w : shadow;
      pending    <= boundary ? 1'b0 : (pending | load);
      AN         <= state_n == seg_pkg::DRIVE ? AN_PAT[dig_n] : AN_OFF;
      SEG        <= (state_n == seg_pkg::BLANK || active_n.blank[dig_n]) ? 8'hFF : {~active_n.dp[dig_n], hex_seg};
      frame_sync <= state_n == seg_pkg::DRIVE && dig_n == 2'd0;
    end
  end
endmodule
